cg_rvarch_opfetch: RTL and testbench

//  Operand-fetch stage between decode and execute. Drives register-file read addresses,

---
 rtl/cg_rvarch_opfetch.sv | 130 +++++++++++++
 tb/tb_cg_rvarch_opfetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cg_rvarch_opfetch.sv
// Operand-fetch stage: regfile addressing, writeback bypass with x0 forced to zero, and a
// valid/ready output register. Define CG_RVARCH_OPFETCH_SCOREBOARD_EN for RAW/WAW stalls.
module cg_rvarch_opfetch #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_NUM      = 32,
  parameter int unsigned ADDR_WIDTH    = $clog2(DATA_NUM),
  parameter int unsigned PAYLOAD_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ADDR_WIDTH-1:0]    i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0]    i_rs2_addr,
  input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
  input  logic                     i_rd_we,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  output logic [ADDR_WIDTH-1:0]    o_rf_rs1_addr,
  input  logic [DATA_WIDTH-1:0]    i_rf_rs1_data,
  output logic [ADDR_WIDTH-1:0]    o_rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0]    i_rf_rs2_data,
  input  logic                     i_wb_we,
  input  logic [ADDR_WIDTH-1:0]    i_wb_addr,
  input  logic [DATA_WIDTH-1:0]    i_wb_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_rs1_data,
  output logic [DATA_WIDTH-1:0]    o_rs2_data,
  output logic [ADDR_WIDTH-1:0]    o_rd_addr,
  output logic                     o_rd_we,
  output logic [PAYLOAD_WIDTH-1:0] o_payload
);

  logic                  hazard;
  logic                  accept;
  logic                  wb_active;
  logic [DATA_WIDTH-1:0] rs1_sel;
  logic [DATA_WIDTH-1:0] rs2_sel;

  assign o_rf_rs1_addr = i_rs1_addr;
  assign o_rf_rs2_addr = i_rs2_addr;

  // A writeback to x0 is architecturally a no-op, so it never bypasses or clears.
  assign wb_active = i_wb_we && (i_wb_addr != '0);

  always_comb begin
    rs1_sel = i_rf_rs1_data;
    if (i_rs1_addr == '0) begin
      rs1_sel = '0;
    end else if (wb_active && (i_wb_addr == i_rs1_addr)) begin
      rs1_sel = i_wb_data;
    end
  end

  always_comb begin
    rs2_sel = i_rf_rs2_data;
    if (i_rs2_addr == '0) begin
      rs2_sel = '0;
    end else if (wb_active && (i_wb_addr == i_rs2_addr)) begin
      rs2_sel = i_wb_data;
    end
  end

  assign o_ready = !hazard && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

`ifdef CG_RVARCH_OPFETCH_SCOREBOARD_EN
  logic [DATA_NUM-1:0] busy_q;
  logic [DATA_NUM-1:0] busy_d;
  logic [DATA_NUM-1:0] wb_clr;
  logic [DATA_NUM-1:0] busy_pend;

  always_comb begin
    wb_clr = '0;
    if (wb_active) begin
      wb_clr[i_wb_addr] = 1'b1;
    end
  end

  // A register cleared by this cycle's writeback no longer blocks: bypass supplies the value.
  assign busy_pend = busy_q & ~wb_clr;

  always_comb begin
    hazard = busy_pend[i_rs1_addr] || busy_pend[i_rs2_addr];
    if (i_rd_we && busy_pend[i_rd_addr]) begin
      hazard = 1'b1;
    end
  end

  // Clear first so that a set for the same register in the same cycle takes priority.
  always_comb begin
    busy_d = busy_pend;
    if (accept && i_rd_we && (i_rd_addr != '0)) begin
      busy_d[i_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_rd_addr  <= '0;
      o_rd_we    <= 1'b0;
      o_payload  <= '0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_rs1_data <= rs1_sel;
      o_rs2_data <= rs2_sel;
      o_rd_addr  <= i_rd_addr;
      o_rd_we    <= i_rd_we;
      o_payload  <= i_payload;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cg_rvarch_opfetch.sv
// Bench for cg_rvarch_opfetch: directed cases then random traffic against a behavioural model.
// Follows CG_RVARCH_OPFETCH_SCOREBOARD_EN the same way as the design.
module tb_cg_rvarch_opfetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_rd_we;
  logic [31:0] i_payload;
  logic [4:0]  o_rf_rs1_addr, o_rf_rs2_addr;
  logic [31:0] i_rf_rs1_data, i_rf_rs2_data;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic [4:0]  o_rd_addr;
  logic        o_rd_we;
  logic [31:0] o_payload;

  always #5 clk = ~clk;

  cg_rvarch_opfetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_rd_addr     (i_rd_addr),
    .i_rd_we       (i_rd_we),
    .i_payload     (i_payload),
    .o_rf_rs1_addr (o_rf_rs1_addr),
    .i_rf_rs1_data (i_rf_rs1_data),
    .o_rf_rs2_addr (o_rf_rs2_addr),
    .i_rf_rs2_data (i_rf_rs2_data),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_rs1_data    (o_rs1_data),
    .o_rs2_data    (o_rs2_data),
    .o_rd_addr     (o_rd_addr),
    .o_rd_we       (o_rd_we),
    .o_payload     (o_payload)
  );

  // Bench-side register file; x0 holds garbage on purpose, the stage must mask it.
  logic [31:0] rf [32];
  assign i_rf_rs1_data = rf[o_rf_rs1_addr];
  assign i_rf_rs2_data = rf[o_rf_rs2_addr];

  // Reference model state
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2, m_pl;
  logic [4:0]  m_rd;
  logic        m_rdwe;
  bit          m_busy [32];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic wbwe,
                                          input logic [4:0] wba, input logic [31:0] wbd);
    if (a == 0) return 32'h0;
    if (wbwe && wba == a) return wbd;
    return rf[a];
  endfunction

  function automatic bit blocked(input logic [4:0] r, input logic wbwe, input logic [4:0] wba);
`ifdef CG_RVARCH_OPFETCH_SCOREBOARD_EN
    return (r != 0) && m_busy[r] && !(wbwe && wba == r);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rdwe = 0; m_pl = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  // One clock: drive, check ready, clock edge, update model, check registered outputs.
  task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rdwe, input logic [31:0] pl,
                       input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic rdy);
    bit          hz, ready, acc;
    logic [31:0] op1, op2;
    i_valid = v; i_rs1_addr = rs1; i_rs2_addr = rs2; i_rd_addr = rd; i_rd_we = rdwe;
    i_payload = pl; i_wb_we = wbwe; i_wb_addr = wba; i_wb_data = wbd; i_ready = rdy;
    #1;
    hz    = blocked(rs1, wbwe, wba) || blocked(rs2, wbwe, wba) || (rdwe && blocked(rd, wbwe, wba));
    ready = !hz && (!m_valid || rdy);
    acc   = v && ready;
    op1   = operand(rs1, wbwe, wba, wbd);
    op2   = operand(rs2, wbwe, wba, wbd);
    check("o_ready", {63'h0, o_ready}, {63'h0, ready});
    check("rf_rs1_addr", {59'h0, o_rf_rs1_addr}, {59'h0, rs1});
    check("rf_rs2_addr", {59'h0, o_rf_rs2_addr}, {59'h0, rs2});
    @(posedge clk);
    #1;
    if (wbwe && wba != 0) rf[wba] = wbd;
    if (wbwe) m_busy[wba] = 0;
    if (acc && rdwe && rd != 0) m_busy[rd] = 1;
    if (acc) begin
      m_valid = 1; m_rs1 = op1; m_rs2 = op2; m_rd = rd; m_rdwe = rdwe; m_pl = pl;
    end else if (rdy) begin
      m_valid = 0;
    end
    check("o_valid", {63'h0, o_valid}, {63'h0, m_valid});
    check("o_rs1_data", {32'h0, o_rs1_data}, {32'h0, m_rs1});
    check("o_rs2_data", {32'h0, o_rs2_data}, {32'h0, m_rs2});
    check("o_rd_addr", {59'h0, o_rd_addr}, {59'h0, m_rd});
    check("o_rd_we", {63'h0, o_rd_we}, {63'h0, m_rdwe});
    check("o_payload", {32'h0, o_payload}, {32'h0, m_pl});
  endtask

  task automatic idle(input logic [31:0] n);
    for (int i = 0; i < int'(n); i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 0;
    i_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_rd_we = 0; i_payload = 0;
    i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0; i_ready = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    rf[2] = 32'h2222_0002;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid", {63'h0, o_valid}, 64'h0);
    check("reset_o_payload", {32'h0, o_payload}, 64'h0);
    rst_n = 1;

    // Bypass: writeback to x1 in the accept cycle feeds rs1.
    cycle(1, 1, 0, 4, 0, 32'hA001, 1, 1, 32'h0000_0810, 1);
    check("bypass_rs1", {32'h0, o_rs1_data}, 64'h810);

    // x0: never bypassed, regfile garbage masked.
    cycle(1, 0, 0, 0, 0, 32'hA002, 1, 0, 32'hDEAD_BEEF, 1);
    check("x0_rs1", {32'h0, o_rs1_data}, 64'h0);
    check("x0_rs2", {32'h0, o_rs2_data}, 64'h0);

    // Backpressure: hold for three cycles, then accept-and-drain together.
    cycle(1, 5, 6, 7, 0, 32'hB000, 1, 5, 32'h1111_2222, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8, 9, 10, 0, 32'hB001, 0, 0, 0, 0);
    check("stall_rs1_held", {32'h0, o_rs1_data}, 64'h1111_2222);
    check("stall_payload_held", {32'h0, o_payload}, 64'hB000);
    cycle(1, 8, 9, 10, 0, 32'hB001, 0, 0, 0, 1);
    check("drain_valid", {63'h0, o_valid}, 64'h1);
    check("drain_payload", {32'h0, o_payload}, 64'hB001);
    idle(1);

    // Hazard on a pending rd=2 write.
    cycle(1, 0, 0, 2, 1, 32'hC000, 0, 0, 0, 1);
`ifdef CG_RVARCH_OPFETCH_SCOREBOARD_EN
    cycle(1, 0, 2, 0, 0, 32'hC001, 0, 0, 0, 1);
    check("raw_stall_valid", {63'h0, o_valid}, 64'h0);
    cycle(1, 0, 2, 0, 0, 32'hC001, 1, 2, 32'h0000_0514, 1);
    check("raw_release_rs2", {32'h0, o_rs2_data}, 64'h514);
    // Set beats clear for the same register in the same cycle.
    cycle(1, 0, 0, 3, 1, 32'hC002, 1, 3, 32'h33, 1);
    cycle(1, 3, 0, 0, 0, 32'hC003, 0, 0, 0, 1);
    check("set_wins_stall", {63'h0, o_valid}, 64'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3, 32'h34, 1);
`else
    cycle(1, 0, 2, 0, 0, 32'hC001, 0, 0, 0, 1);
    check("no_sb_rs2", {32'h0, o_rs2_data}, 64'h2222_0002);
`endif

    // Reset in the middle of a held instruction.
    cycle(1, 4, 5, 6, 0, 32'hD000, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    model_reset();
    check("midrst_valid", {63'h0, o_valid}, 64'h0);
    check("midrst_rs1", {32'h0, o_rs1_data}, 64'h0);
    check("midrst_payload", {32'h0, o_payload}, 64'h0);
    i_valid = 0;
    #10;
    rst_n = 1;
    #1;
    check("post_rst_ready", {63'h0, o_ready}, 64'h1);
    idle(1);

    // Random traffic on a small register window to hit bypass and hazards often.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cycle(r[0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), r[1], $urandom, r[2], 5'($urandom_range(0, 7)),
            $urandom, r[4:3] != 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
